// File: rtl/cache_mem_arbiter.sv
// Arbiter between I-cache and D-cache line ports and a single memory port.
// Captures pulse-strobe requests, serialises them one transaction at a time,
// breaks ties round-robin, and forces completion if memory never answers.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   strobe/addr_icache_i          I-cache read request (always a read)
//   rdata/done_icache_o           I-cache response data and completion pulse
//   strobe/addr/rw/wdata_dcache_i D-cache request (rw = 1 write)
//   rdata/done_dcache_o           D-cache response data and completion pulse
//   mem_strobe/addr/rw/wdata_o    memory request, valid for one ISSUE cycle
//   mem_rdata_i, mem_done_i       memory response
//   err_timeout_o                 sticky timeout flag
module cache_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LINE_WIDTH     = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  strobe_icache_i,
  input  logic [ADDR_WIDTH-1:0] addr_icache_i,
  output logic [LINE_WIDTH-1:0] rdata_icache_o,
  output logic                  done_icache_o,
  input  logic                  strobe_dcache_i,
  input  logic [ADDR_WIDTH-1:0] addr_dcache_i,
  input  logic                  rw_dcache_i,
  input  logic [LINE_WIDTH-1:0] wdata_dcache_i,
  output logic [LINE_WIDTH-1:0] rdata_dcache_o,
  output logic                  done_dcache_o,
  output logic                  mem_strobe_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rw_o,
  output logic [LINE_WIDTH-1:0] mem_wdata_o,
  input  logic [LINE_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_done_i,
  output logic                  err_timeout_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);
  // Byte-offset bits within a line; cleared on the memory address.
  localparam logic [ADDR_WIDTH-1:0] OfsMask = ADDR_WIDTH'((LINE_WIDTH / 8) - 1);
  localparam logic GrantI = 1'b0;
  localparam logic GrantD = 1'b1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e state_q, state_d;
  logic pend_i_q, pend_i_d, pend_d_q, pend_d_d;
  logic [ADDR_WIDTH-1:0] addr_i_q, addr_i_d, addr_d_q, addr_d_d;
  logic rw_d_q, rw_d_d;
  logic [LINE_WIDTH-1:0] wdata_d_q, wdata_d_d;
  logic winner_q, winner_d, last_grant_q, last_grant_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [LINE_WIDTH-1:0] rdata_i_q, rdata_i_d, rdata_d_q, rdata_d_d;
  logic req_i, req_d;
  logic [LINE_WIDTH-1:0] resp_data;

  // A strobe is only captured when its port is idle; pending stays set while in service.
  assign req_i = pend_i_q | strobe_icache_i;
  assign req_d = pend_d_q | strobe_dcache_i;

  always_comb begin
    state_d      = state_q;
    pend_i_d     = pend_i_q;
    pend_d_d     = pend_d_q;
    addr_i_d     = addr_i_q;
    addr_d_d     = addr_d_q;
    rw_d_d       = rw_d_q;
    wdata_d_d    = wdata_d_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    rdata_i_d    = rdata_i_q;
    rdata_d_d    = rdata_d_q;
    resp_data    = '0;

    if (strobe_icache_i && !pend_i_q) begin
      pend_i_d = 1'b1;
      addr_i_d = addr_icache_i;
    end
    if (strobe_dcache_i && !pend_d_q) begin
      pend_d_d  = 1'b1;
      addr_d_d  = addr_dcache_i;
      rw_d_d    = rw_dcache_i;
      wdata_d_d = wdata_dcache_i;
    end

    unique case (state_q)
      StIdle: begin
        if (req_i && req_d) begin
          // Round-robin only advances on a real tie.
          winner_d     = (last_grant_q == GrantD) ? GrantI : GrantD;
          last_grant_d = winner_d;
          state_d      = StIssue;
        end else if (req_i || req_d) begin
          winner_d = req_d ? GrantD : GrantI;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (mem_done_i || cnt_q == CntMax) begin
          // Writes and timeouts return a zero line.
          if (mem_done_i && !(winner_q == GrantD && rw_d_q)) resp_data = mem_rdata_i;
          if (!mem_done_i) err_d = 1'b1;
          if (winner_q == GrantD) rdata_d_d = resp_data;
          else                    rdata_i_d = resp_data;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        // Clearing here also discards a same-cycle strobe from the completing port.
        if (winner_q == GrantD) pend_d_d = 1'b0;
        else                    pend_i_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pend_i_q     <= 1'b0;
      pend_d_q     <= 1'b0;
      addr_i_q     <= '0;
      addr_d_q     <= '0;
      rw_d_q       <= 1'b0;
      wdata_d_q    <= '0;
      winner_q     <= GrantI;
      last_grant_q <= GrantD;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      rdata_i_q    <= '0;
      rdata_d_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_i_q     <= pend_i_d;
      pend_d_q     <= pend_d_d;
      addr_i_q     <= addr_i_d;
      addr_d_q     <= addr_d_d;
      rw_d_q       <= rw_d_d;
      wdata_d_q    <= wdata_d_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      rdata_i_q    <= rdata_i_d;
      rdata_d_q    <= rdata_d_d;
    end
  end

  always_comb begin
    mem_strobe_o = 1'b0;
    mem_addr_o   = '0;
    mem_rw_o     = 1'b0;
    mem_wdata_o  = '0;
    if (state_q == StIssue) begin
      mem_strobe_o = 1'b1;
      mem_addr_o   = ((winner_q == GrantD) ? addr_d_q : addr_i_q) & ~OfsMask;
      mem_rw_o     = (winner_q == GrantD) && rw_d_q;
      mem_wdata_o  = mem_rw_o ? wdata_d_q : '0;
    end
  end

  assign done_icache_o  = (state_q == StResp) && (winner_q == GrantI);
  assign done_dcache_o  = (state_q == StResp) && (winner_q == GrantD);
  assign rdata_icache_o = rdata_i_q;
  assign rdata_dcache_o = rdata_d_q;
  assign err_timeout_o  = err_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         strobe_icache_i;
  logic [31:0]  addr_icache_i;
  logic [255:0] rdata_icache_o;
  logic         done_icache_o;
  logic         strobe_dcache_i;
  logic [31:0]  addr_dcache_i;
  logic         rw_dcache_i;
  logic [255:0] wdata_dcache_i;
  logic [255:0] rdata_dcache_o;
  logic         done_dcache_o;
  logic         mem_strobe_o;
  logic [31:0]  mem_addr_o;
  logic         mem_rw_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_done_i;
  logic         err_timeout_o;

  int n_chk = 0;
  int n_fail = 0;
  int n_strobe, n_done_i;

  logic [255:0] pat_a, pat_1, pat_5, r1, r2, r3, r4, r6, r7;

  cache_mem_arbiter #(
    .ADDR_WIDTH    (32),
    .LINE_WIDTH    (256),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .strobe_icache_i(strobe_icache_i),
    .addr_icache_i  (addr_icache_i),
    .rdata_icache_o (rdata_icache_o),
    .done_icache_o  (done_icache_o),
    .strobe_dcache_i(strobe_dcache_i),
    .addr_dcache_i  (addr_dcache_i),
    .rw_dcache_i    (rw_dcache_i),
    .wdata_dcache_i (wdata_dcache_i),
    .rdata_dcache_o (rdata_dcache_o),
    .done_dcache_o  (done_dcache_o),
    .mem_strobe_o   (mem_strobe_o),
    .mem_addr_o     (mem_addr_o),
    .mem_rw_o       (mem_rw_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .mem_done_i     (mem_done_i),
    .err_timeout_o  (err_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count();
    n_strobe += int'(mem_strobe_o);
    n_done_i += int'(done_icache_o);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    strobe_icache_i = 1'b0;
    strobe_dcache_i = 1'b0;
    mem_done_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    pat_a = {8{32'hAAAA_AAAA}};
    pat_1 = {8{32'h1111_1111}};
    pat_5 = {8{32'h5555_5555}};
    r1 = {8{32'h0101_0101}};
    r2 = {8{32'h0202_0202}};
    r3 = {8{32'h0303_0303}};
    r4 = {8{32'h0404_0404}};
    r6 = {8{32'h0606_0606}};
    r7 = {8{32'h0707_0707}};
    addr_icache_i = '0;
    addr_dcache_i = '0;
    rw_dcache_i = 1'b0;
    wdata_dcache_i = '0;
    mem_rdata_i = '0;
    do_reset();

    // Reset state
    chk("rst_mem_strobe", 256'(mem_strobe_o), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
    chk("rst_done_i", 256'(done_icache_o), 256'(0));
    chk("rst_done_d", 256'(done_dcache_o), 256'(0));
    chk("rst_err", 256'(err_timeout_o), 256'(0));
    chk("rst_rdata_i", rdata_icache_o, 256'(0));
    chk("rst_rdata_d", rdata_dcache_o, 256'(0));

    // I-cache read, memory answers on the third WAIT cycle
    strobe_icache_i = 1'b1;
    addr_icache_i = 32'h0000_1234;
    step();
    strobe_icache_i = 1'b0;
    chk("ird_strobe", 256'(mem_strobe_o), 256'(1));
    chk("ird_addr", 256'(mem_addr_o), 256'(32'h0000_1220));
    chk("ird_rw", 256'(mem_rw_o), 256'(0));
    chk("ird_wdata", mem_wdata_o, 256'(0));
    step();
    chk("ird_wait_strobe", 256'(mem_strobe_o), 256'(0));
    chk("ird_wait_addr", 256'(mem_addr_o), 256'(0));
    mem_done_i = 1'b1;  // stray done on wrong cycle is fine, we are in WAIT
    mem_done_i = 1'b0;
    step();
    step();
    mem_done_i = 1'b1;
    mem_rdata_i = pat_a;
    step();
    mem_done_i = 1'b0;
    mem_rdata_i = '0;
    chk("ird_done_i", 256'(done_icache_o), 256'(1));
    chk("ird_done_d", 256'(done_dcache_o), 256'(0));
    chk("ird_rdata", rdata_icache_o, pat_a);
    step();
    chk("ird_done_clear", 256'(done_icache_o), 256'(0));
    chk("ird_rdata_hold", rdata_icache_o, pat_a);

    // D-cache write
    strobe_dcache_i = 1'b1;
    addr_dcache_i = 32'h8000_0040;
    rw_dcache_i = 1'b1;
    wdata_dcache_i = pat_1;
    step();
    strobe_dcache_i = 1'b0;
    rw_dcache_i = 1'b0;
    wdata_dcache_i = '0;
    chk("dwr_strobe", 256'(mem_strobe_o), 256'(1));
    chk("dwr_addr", 256'(mem_addr_o), 256'(32'h8000_0040));
    chk("dwr_rw", 256'(mem_rw_o), 256'(1));
    chk("dwr_wdata", mem_wdata_o, pat_1);
    step();
    chk("dwr_wait_rw", 256'(mem_rw_o), 256'(0));
    chk("dwr_wait_wdata", mem_wdata_o, 256'(0));
    mem_done_i = 1'b1;
    mem_rdata_i = pat_5;
    step();
    mem_done_i = 1'b0;
    chk("dwr_done_d", 256'(done_dcache_o), 256'(1));
    chk("dwr_done_i", 256'(done_icache_o), 256'(0));
    chk("dwr_rdata_zero", rdata_dcache_o, 256'(0));
    chk("dwr_rdata_i_hold", rdata_icache_o, pat_a);
    step();

    // Tie after reset: I-cache first, D-cache issues at M+3
    do_reset();
    strobe_icache_i = 1'b1;
    addr_icache_i = 32'h0000_0100;
    strobe_dcache_i = 1'b1;
    addr_dcache_i = 32'h0000_0200;
    rw_dcache_i = 1'b0;
    step();
    strobe_icache_i = 1'b0;
    strobe_dcache_i = 1'b0;
    chk("tie1_addr_i", 256'(mem_addr_o), 256'(32'h0000_0100));
    step();
    mem_done_i = 1'b1;
    mem_rdata_i = r1;
    step();
    mem_done_i = 1'b0;
    chk("tie1_done_i", 256'(done_icache_o), 256'(1));
    chk("tie1_rdata_i", rdata_icache_o, r1);
    step();
    chk("tie1_m2_idle", 256'(mem_strobe_o), 256'(0));
    step();
    chk("tie1_m3_strobe", 256'(mem_strobe_o), 256'(1));
    chk("tie1_m3_addr_d", 256'(mem_addr_o), 256'(32'h0000_0200));
    step();
    mem_done_i = 1'b1;
    mem_rdata_i = r2;
    step();
    mem_done_i = 1'b0;
    chk("tie1_done_d", 256'(done_dcache_o), 256'(1));
    chk("tie1_rdata_d", rdata_dcache_o, r2);
    step();

    // Repeat the tie: D-cache wins this time
    strobe_icache_i = 1'b1;
    addr_icache_i = 32'h0000_0300;
    strobe_dcache_i = 1'b1;
    addr_dcache_i = 32'h0000_0400;
    step();
    strobe_icache_i = 1'b0;
    strobe_dcache_i = 1'b0;
    chk("tie2_addr_d", 256'(mem_addr_o), 256'(32'h0000_0400));
    step();
    mem_done_i = 1'b1;
    mem_rdata_i = r3;
    step();
    mem_done_i = 1'b0;
    chk("tie2_done_d", 256'(done_dcache_o), 256'(1));
    chk("tie2_rdata_d", rdata_dcache_o, r3);
    step();
    step();
    chk("tie2_addr_i", 256'(mem_addr_o), 256'(32'h0000_0300));
    step();
    mem_done_i = 1'b1;
    mem_rdata_i = r4;
    step();
    mem_done_i = 1'b0;
    chk("tie2_done_i", 256'(done_icache_o), 256'(1));
    chk("tie2_rdata_i", rdata_icache_o, r4);
    step();

    // Timeout with TIMEOUT_CYCLES = 8: eight WAIT cycles, then forced RESP
    strobe_dcache_i = 1'b1;
    addr_dcache_i = 32'h0000_0500;
    rw_dcache_i = 1'b0;
    step();
    strobe_dcache_i = 1'b0;
    step();
    for (int i = 0; i < 7; i++) step();
    chk("to_err_before", 256'(err_timeout_o), 256'(0));
    chk("to_no_done_yet", 256'(done_dcache_o), 256'(0));
    step();
    chk("to_err", 256'(err_timeout_o), 256'(1));
    chk("to_done_d", 256'(done_dcache_o), 256'(1));
    chk("to_rdata_zero", rdata_dcache_o, 256'(0));
    step();
    chk("to_err_sticky", 256'(err_timeout_o), 256'(1));
    strobe_icache_i = 1'b1;
    addr_icache_i = 32'h0000_0900;
    step();
    strobe_icache_i = 1'b0;
    step();
    mem_done_i = 1'b1;
    mem_rdata_i = r1;
    step();
    mem_done_i = 1'b0;
    chk("to_next_done_i", 256'(done_icache_o), 256'(1));
    chk("to_err_still", 256'(err_timeout_o), 256'(1));
    step();
    do_reset();
    chk("to_err_cleared", 256'(err_timeout_o), 256'(0));

    // Reset during WAIT, late done afterwards is ignored
    strobe_icache_i = 1'b1;
    addr_icache_i = 32'h0000_0600;
    step();
    strobe_icache_i = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mem_done_i = 1'b1;
    mem_rdata_i = pat_a;
    step();
    mem_done_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rmid_done_i", 256'(done_icache_o), 256'(0));
      chk("rmid_done_d", 256'(done_dcache_o), 256'(0));
      chk("rmid_strobe", 256'(mem_strobe_o), 256'(0));
      chk("rmid_rdata_i", rdata_icache_o, 256'(0));
      step();
    end

    // Repeated I-cache strobe while pending behind a D-cache transaction
    n_strobe = 0;
    n_done_i = 0;
    strobe_dcache_i = 1'b1;
    addr_dcache_i = 32'h0000_0800;
    rw_dcache_i = 1'b0;
    step();
    strobe_dcache_i = 1'b0;
    count();
    strobe_icache_i = 1'b1;
    addr_icache_i = 32'h0000_0700;
    step();
    count();
    addr_icache_i = 32'h0000_07E0;
    step();
    count();
    strobe_icache_i = 1'b0;
    mem_done_i = 1'b1;
    mem_rdata_i = r6;
    step();
    count();
    mem_done_i = 1'b0;
    chk("dup_done_d", 256'(done_dcache_o), 256'(1));
    step();
    count();
    step();
    count();
    chk("dup_addr_first", 256'(mem_addr_o), 256'(32'h0000_0700));
    step();
    count();
    mem_done_i = 1'b1;
    mem_rdata_i = r7;
    step();
    count();
    mem_done_i = 1'b0;
    chk("dup_rdata_i", rdata_icache_o, r7);
    for (int i = 0; i < 6; i++) begin
      step();
      count();
    end
    chk("dup_strobe_count", 256'(n_strobe), 256'(2));
    chk("dup_done_i_count", 256'(n_done_i), 256'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
